// File: rtl/ssd_scan_rx_pkg.sv
// ssd_scan_rx_pkg: shared display constants (active-low segment patterns {a,b,c,d,e,f,g,dp}, dp off)
package ssd_scan_rx_pkg;
    localparam int DEF_SSD_NUM       = 4;
    localparam int DEF_SSD_BIT_WIDTH = 8;
    localparam logic [7:0] SS_0     = 8'h03;
    localparam logic [7:0] SS_1     = 8'h9F;
    localparam logic [7:0] SS_2     = 8'h25;
    localparam logic [7:0] SS_3     = 8'h0D;
    localparam logic [7:0] SS_4     = 8'h99;
    localparam logic [7:0] SS_5     = 8'h49;
    localparam logic [7:0] SS_6     = 8'h41;
    localparam logic [7:0] SS_7     = 8'h1F;
    localparam logic [7:0] SS_8     = 8'h01;
    localparam logic [7:0] SS_9     = 8'h09;
    localparam logic [7:0] SS_A     = 8'h11;
    localparam logic [7:0] SS_B     = 8'hC1;
    localparam logic [7:0] SS_C     = 8'h63;
    localparam logic [7:0] SS_D     = 8'h85;
    localparam logic [7:0] SS_E     = 8'h61;
    localparam logic [7:0] SS_F     = 8'h71;
    localparam logic [7:0] SS_BLANK = 8'hFF;
    localparam logic [15:0][7:0] SS_HEX = {SS_F, SS_E, SS_D, SS_C, SS_B, SS_A, SS_9, SS_8,
                                           SS_7, SS_6, SS_5, SS_4, SS_3, SS_2, SS_1, SS_0};
endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: 7-bit active-low segment pattern {a..g} -> hex value, valid and blank flags
// Ports: pat in; valid (pattern is 0-F), blank (all segments off), value (decoded digit) out.
module ssd_seg_decode
    import ssd_scan_rx_pkg::*;
(
    input  logic [6:0] pat,
    output logic       valid,
    output logic       blank,
    output logic [3:0] value
);
    always_comb begin
        valid = 1'b0;
        value = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (pat == SS_HEX[k][7:1]) begin
                valid = 1'b1;
                value = 4'(k);
            end
        end
        blank = pat == SS_BLANK[7:1];
    end
endmodule

// File: rtl/ssd_scan_rx.sv
// ssd_scan_rx: receiver for the scanned 7-segment bus, decodes each settled digit dwell
// Ports: clk, rst_n (async, active-low); segs/ssd_ctl scanned bus in (active-low);
//        digits/dp/dig_valid per-digit captures out; frame_done, pat_err, ctl_err one-cycle pulses.
module ssd_scan_rx
    import ssd_scan_rx_pkg::*;
#(
    parameter int SSD_NUM       = DEF_SSD_NUM,
    parameter int SSD_BIT_WIDTH = DEF_SSD_BIT_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SSD_BIT_WIDTH-1:0] segs,
    input  logic [SSD_NUM-1:0]       ssd_ctl,
    output logic [4*SSD_NUM-1:0]     digits,
    output logic [SSD_NUM-1:0]       dp,
    output logic [SSD_NUM-1:0]       dig_valid,
    output logic                     frame_done,
    output logic                     pat_err,
    output logic                     ctl_err
);
    localparam int BW = SSD_BIT_WIDTH + SSD_NUM;
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

    logic [BW-1:0]            s1, s2, prev;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     captured, stable, cap, wr, multi;
    logic [SSD_BIT_WIDTH-1:0] seg_s;
    logic [SSD_NUM-1:0]       ctl_s, sel, mask;
    logic                     dec_valid, dec_blank;
    logic [3:0]               dec_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= {segs, ssd_ctl};
            s2   <= s1;
            prev <= s2;
        end
    end

    assign seg_s = s2[BW-1:SSD_NUM];
    assign ctl_s = s2[SSD_NUM-1:0];
    assign sel   = ~ctl_s;

    // The capture registers on the same edge the counter reaches its top value,
    // so one strobe per dwell; captured holds it off until the bus changes.
    always_comb begin
        stable  = s2 == prev;
        cnt_nxt = !stable ? '0 : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
        cap     = stable && cnt_nxt == CNT_MAX && !captured;
        wr      = cap && $countones(sel) == 1;
        multi   = cap && $countones(sel) > 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            captured <= stable && (captured || cap);
        end
    end

    ssd_seg_decode u_dec (
        .pat   (seg_s[SSD_BIT_WIDTH-1 -: 7]),
        .valid (dec_valid),
        .blank (dec_blank),
        .value (dec_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= '0;
            dp        <= '0;
            dig_valid <= '0;
            pat_err   <= 1'b0;
            ctl_err   <= 1'b0;
        end else begin
            pat_err <= wr && !dec_valid && !dec_blank;
            ctl_err <= multi;
            for (int i = 0; i < SSD_NUM; i++) begin
                if (wr && sel[i]) begin
                    dp[i]        <= ~seg_s[0];
                    dig_valid[i] <= dec_valid;
                    if (dec_valid)
                        digits[4*i +: 4] <= dec_value;
                end
            end
        end
    end

    // A full mask is reported and cleared together; a same-cycle capture lands in the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= &mask;
            mask       <= (&mask ? '0 : mask) | (wr ? sel : '0);
        end
    end
endmodule

// File: tb/tb_ssd_scan_rx.sv
// tb_ssd_scan_rx: directed self-checking bench for ssd_scan_rx
module tb_ssd_scan_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  segs = 8'hFF;
    logic [3:0]  ssd_ctl = 4'b1111;
    logic [15:0] digits;
    logic [3:0]  dp, dig_valid;
    logic        frame_done, pat_err, ctl_err;
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;
    int ce_cnt = 0;

    ssd_scan_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segs       (segs),
        .ssd_ctl    (ssd_ctl),
        .digits     (digits),
        .dp         (dp),
        .dig_valid  (dig_valid),
        .frame_done (frame_done),
        .pat_err    (pat_err),
        .ctl_err    (ctl_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (pat_err) pe_cnt++;
        if (ctl_err) ce_cnt++;
    end

    task automatic drive(input logic [3:0] c, input logic [7:0] s, input int n);
        @(posedge clk);
        #1;
        ssd_ctl = c;
        segs = s;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({digits, dp, dig_valid, frame_done, pat_err, ctl_err} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {digits, dp, dig_valid, frame_done, pat_err, ctl_err});
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (fd_cnt + pe_cnt + ce_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle_pulses: got %0d expected 0", fd_cnt + pe_cnt + ce_cnt);
        end
    endtask

    task automatic test_first_capture;
        int pe0, ce0;
        pe0 = pe_cnt;
        ce0 = ce_cnt;
        @(posedge clk);
        #1;
        ssd_ctl = 4'b1110;
        segs = 8'h25;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dig_valid !== 4'b0000) begin
            errors++;
            $display("FAIL first_edge5_valid: got %b expected 0000", dig_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dig_valid !== 4'b0001) begin
            errors++;
            $display("FAIL first_edge6_valid: got %b expected 0001", dig_valid);
        end
        checks++;
        if (digits[3:0] !== 4'h2) begin
            errors++;
            $display("FAIL first_edge6_digit: got %h expected 2", digits[3:0]);
        end
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (pe_cnt != pe0 || ce_cnt != ce0) begin
            errors++;
            $display("FAIL first_no_err: got pat %0d ctl %0d expected 0 0", pe_cnt - pe0, ce_cnt - ce0);
        end
    endtask

    task automatic test_scan_frame;
        int fd0;
        fd0 = fd_cnt;
        drive(4'b1110, 8'h0D, 10);
        drive(4'b1101, 8'h99, 10);
        drive(4'b1011, 8'h49, 10);
        drive(4'b0111, 8'h41, 10);
        drive(4'b1111, 8'hFF, 10);
        checks++;
        if (digits !== 16'h6543) begin
            errors++;
            $display("FAIL scan_digits: got %h expected 6543", digits);
        end
        checks++;
        if (dig_valid !== 4'b1111) begin
            errors++;
            $display("FAIL scan_valid: got %b expected 1111", dig_valid);
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL scan_frame_done: got %0d expected 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_dp;
        drive(4'b1110, 8'h02, 10);
        checks++;
        if (digits[3:0] !== 4'h0 || dig_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL dp_digit: got %h/%b expected 0/1", digits[3:0], dig_valid[0]);
        end
        checks++;
        if (dp !== 4'b0001) begin
            errors++;
            $display("FAIL dp_flag: got %b expected 0001", dp);
        end
    endtask

    task automatic test_pattern_err;
        int pe0;
        pe0 = pe_cnt;
        drive(4'b1101, 8'h7F, 10);
        checks++;
        if (pe_cnt - pe0 !== 1) begin
            errors++;
            $display("FAIL bad_pat_err: got %0d expected 1", pe_cnt - pe0);
        end
        checks++;
        if (dig_valid[1] !== 1'b0 || digits[7:4] !== 4'h4) begin
            errors++;
            $display("FAIL bad_hold: got %b/%h expected 0/4", dig_valid[1], digits[7:4]);
        end
        pe0 = pe_cnt;
        drive(4'b1101, 8'hFF, 10);
        checks++;
        if (pe_cnt - pe0 !== 0) begin
            errors++;
            $display("FAIL blank_pat_err: got %0d expected 0", pe_cnt - pe0);
        end
        checks++;
        if (dig_valid !== 4'b1101 || digits !== 16'h6540) begin
            errors++;
            $display("FAIL blank_hold: got %b/%h expected 1101/6540", dig_valid, digits);
        end
    endtask

    task automatic test_ctl_err_short;
        int ce0, fd0;
        drive(4'b1111, 8'hFF, 10);
        ce0 = ce_cnt;
        fd0 = fd_cnt;
        drive(4'b1100, 8'h03, 10);
        checks++;
        if (ce_cnt - ce0 !== 1) begin
            errors++;
            $display("FAIL ctl_err_count: got %0d expected 1", ce_cnt - ce0);
        end
        checks++;
        if (digits !== 16'h6540 || dig_valid !== 4'b1101 || fd_cnt != fd0) begin
            errors++;
            $display("FAIL ctl_err_hold: got %h/%b expected 6540/1101", digits, dig_valid);
        end
        drive(4'b1110, 8'h03, 3);
        drive(4'b1111, 8'hFF, 10);
        checks++;
        if (dp !== 4'b0001) begin
            errors++;
            $display("FAIL short_dwell_dp: got %b expected 0001", dp);
        end
    endtask

    task automatic test_back_to_back;
        int fd0;
        fd0 = fd_cnt;
        drive(4'b1011, 8'h11, 8);
        drive(4'b0111, 8'h85, 8);
        drive(4'b1111, 8'hFF, 5);
        checks++;
        if (digits !== 16'hDA40) begin
            errors++;
            $display("FAIL b2b_digits: got %h expected DA40", digits);
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL b2b_frame_done: got %0d expected 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #1;
        ssd_ctl = 4'b1101;
        segs = 8'h0D;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({digits, dp, dig_valid, frame_done, pat_err, ctl_err} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0", {digits, dp, dig_valid, frame_done, pat_err, ctl_err});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dig_valid !== 4'b0000) begin
            errors++;
            $display("FAIL async_early_capture: got %b expected 0000", dig_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dig_valid !== 4'b0010 || digits !== 16'h0030) begin
            errors++;
            $display("FAIL async_capture: got %b/%h expected 0010/0030", dig_valid, digits);
        end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_scan_frame();
        test_dp();
        test_pattern_err();
        test_ctl_err_short();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
